// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: the core LSU has priority, and a JTAG debug port gets
// a forced slot once it has been blocked for STARVE_LIMIT consecutive cycles.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic [3:0]  core_sel_i,
  output logic        core_gnt_o,
  output logic        core_stall_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,

  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [31:0] dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  input  logic [3:0]  dbg_sel_i,
  output logic        dbg_gnt_o,
  output logic        dbg_rvalid_o,
  output logic [31:0] dbg_rdata_o,

  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_sel_o,
  input  logic [31:0] ram_rdata_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RSP_CORE = 2'd1,
    RSP_DBG  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             rd_q, rd_d;
  logic             core_rvalid_q, core_rvalid_d;
  logic             dbg_rvalid_q, dbg_rvalid_d;
  logic             core_gnt, dbg_gnt;

  // Grants are gated by reset so every output is quiet while rst_i is held.
  always_comb begin
    dbg_gnt  = ~rst_i & dbg_req_i & (~core_req_i | (starve_q == LIMIT));
    core_gnt = ~rst_i & core_req_i & ~dbg_gnt;
  end

  always_comb begin
    core_gnt_o   = core_gnt;
    dbg_gnt_o    = dbg_gnt;
    core_stall_o = ~rst_i & core_req_i & ~core_gnt;
    ram_ce_o     = core_gnt | dbg_gnt;
    ram_we_o     = 1'b0;
    ram_addr_o   = 32'h0;
    ram_wdata_o  = 32'h0;
    ram_sel_o    = 4'h0;
    if (core_gnt) begin
      ram_we_o    = core_we_i;
      ram_addr_o  = core_addr_i;
      ram_wdata_o = core_wdata_i;
      ram_sel_o   = core_sel_i;
    end else if (dbg_gnt) begin
      ram_we_o    = dbg_we_i;
      ram_addr_o  = dbg_addr_i;
      ram_wdata_o = dbg_wdata_i;
      ram_sel_o   = dbg_sel_i;
    end
  end

  // Counter saturates at LIMIT; at LIMIT the debug grant is forced, which clears it.
  always_comb begin
    starve_d = '0;
    if (dbg_req_i && !dbg_gnt) begin
      starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = IDLE;
    rd_d          = 1'b0;
    core_rvalid_d = 1'b0;
    dbg_rvalid_d  = 1'b0;
    if (core_gnt) begin
      state_d       = RSP_CORE;
      rd_d          = ~core_we_i;
      core_rvalid_d = 1'b1;
    end else if (dbg_gnt) begin
      state_d      = RSP_DBG;
      rd_d         = ~dbg_we_i;
      dbg_rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      starve_q      <= '0;
      rd_q          <= 1'b0;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      rd_q          <= rd_d;
      core_rvalid_q <= core_rvalid_d;
      dbg_rvalid_q  <= dbg_rvalid_d;
    end
  end

  // Responses are dropped combinationally while reset is asserted.
  always_comb begin
    core_rvalid_o = ~rst_i & core_rvalid_q;
    dbg_rvalid_o  = ~rst_i & dbg_rvalid_q;
    core_rdata_o  = (core_rvalid_o && rd_q) ? ram_rdata_i : 32'h0;
    dbg_rdata_o   = (dbg_rvalid_o && rd_q) ? ram_rdata_i : 32'h0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a cycle predictor checks grants and RAM muxing and
// queues expected responses; an independent monitor checks every response cycle.
module tb_dmem_arbiter;

  localparam int STARVE_LIMIT = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i, core_we_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic [3:0]  core_sel_i;
  logic        core_gnt_o, core_stall_o, core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        dbg_req_i, dbg_we_i;
  logic [31:0] dbg_addr_i, dbg_wdata_i;
  logic [3:0]  dbg_sel_i;
  logic        dbg_gnt_o, dbg_rvalid_o;
  logic [31:0] dbg_rdata_o;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_rdata_i;

  dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_sel_i(core_sel_i), .core_gnt_o(core_gnt_o),
    .core_stall_o(core_stall_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_sel_i(dbg_sel_i), .dbg_gnt_o(dbg_gnt_o),
    .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_sel_o(ram_sel_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int due;
    bit dbg;
    bit rd;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   blocked = 0;
  bit   last_core_gnt = 1'b0;
  bit   last_dbg_gnt = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Predictor: debug wins when the core is idle or it has waited STARVE_LIMIT cycles.
  always @(negedge clk_i) begin
    bit          eg_c, eg_d, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_sel;
    eg_c = 1'b0;
    eg_d = 1'b0;
    if (!rst_i) begin
      eg_d = dbg_req_i && (!core_req_i || blocked >= STARVE_LIMIT);
      eg_c = core_req_i && !eg_d;
    end
    e_we = 1'b0; e_addr = 32'h0; e_wdata = 32'h0; e_sel = 4'h0;
    if (eg_c) begin
      e_we = core_we_i; e_addr = core_addr_i; e_wdata = core_wdata_i; e_sel = core_sel_i;
    end else if (eg_d) begin
      e_we = dbg_we_i; e_addr = dbg_addr_i; e_wdata = dbg_wdata_i; e_sel = dbg_sel_i;
    end
    check("core_gnt", 32'(core_gnt_o), 32'(eg_c));
    check("dbg_gnt", 32'(dbg_gnt_o), 32'(eg_d));
    check("core_stall", 32'(core_stall_o), 32'(!rst_i && core_req_i && !eg_c));
    check("ram_ce", 32'(ram_ce_o), 32'(eg_c || eg_d));
    check("ram_we", 32'(ram_we_o), 32'(e_we));
    check("ram_addr", ram_addr_o, e_addr);
    check("ram_wdata", ram_wdata_o, e_wdata);
    check("ram_sel", 32'(ram_sel_o), 32'(e_sel));
    check("starve_cnt", 32'(dut.starve_q), 32'(blocked));
    if (eg_c || eg_d) sb.push_back('{due: cyc + 1, dbg: eg_d, rd: !e_we});
    if (rst_i || !dbg_req_i || eg_d) blocked = 0;
    else blocked = blocked + 1;
    last_core_gnt = eg_c;
    last_dbg_gnt  = eg_d;
  end

  // Monitor: a response is owed exactly one cycle after its grant unless reset intervenes.
  always @(negedge clk_i) begin
    bit          x_core, x_dbg;
    logic [31:0] x_data;
    rsp_t        item;
    x_core = 1'b0;
    x_dbg  = 1'b0;
    x_data = 32'h0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      item = sb.pop_front();
      if (!rst_i) begin
        x_core = !item.dbg;
        x_dbg  = item.dbg;
        x_data = item.rd ? ram_rdata_i : 32'h0;
      end
    end
    check("core_rvalid", 32'(core_rvalid_o), 32'(x_core));
    check("dbg_rvalid", 32'(dbg_rvalid_o), 32'(x_dbg));
    check("core_rdata", core_rdata_o, x_core ? x_data : 32'h0);
    check("dbg_rdata", dbg_rdata_o, x_dbg ? x_data : 32'h0);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    ram_rdata_i = $urandom;
  endtask

  task automatic set_core(input bit req, input bit we, input logic [31:0] addr);
    core_req_i = req; core_we_i = we; core_addr_i = addr;
    core_wdata_i = $urandom; core_sel_i = 4'($urandom_range(1, 15));
  endtask

  task automatic set_dbg(input bit req, input bit we, input logic [31:0] addr);
    dbg_req_i = req; dbg_we_i = we; dbg_addr_i = addr;
    dbg_wdata_i = $urandom; dbg_sel_i = 4'($urandom_range(1, 15));
  endtask

  task automatic drive_random(input int core_pct);
    rst_i = ($urandom_range(0, 99) < 2);
    if (!(core_req_i && !last_core_gnt && $urandom_range(0, 15) != 0))
      set_core($urandom_range(0, 99) < core_pct, 1'($urandom_range(0, 1)), $urandom);
    if (!(dbg_req_i && !last_dbg_gnt && $urandom_range(0, 15) != 0))
      set_dbg($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)), $urandom);
  endtask

  initial begin
    rst_i = 1'b1;
    ram_rdata_i = 32'h0;
    set_core(1'b0, 1'b0, 32'h0);
    set_dbg(1'b0, 1'b0, 32'h0);
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // Lone core read of 0x100, then idle for its response.
    set_core(1'b1, 1'b0, 32'h100);
    tick();
    set_core(1'b0, 1'b0, 32'h0);
    tick(); tick();

    // Core and debug contend for three cycles, then the core backs off.
    set_core(1'b1, 1'b0, 32'h200);
    set_dbg(1'b1, 1'b0, 32'h300);
    tick(); tick(); tick();
    set_core(1'b0, 1'b0, 32'h0);
    tick();
    set_dbg(1'b0, 1'b0, 32'h0);
    tick(); tick();

    // Saturating core traffic with a pending debug write.
    set_dbg(1'b1, 1'b1, 32'h400);
    for (int i = 0; i < 12; i++) begin
      set_core(1'b1, 1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * i));
      tick();
      if (last_dbg_gnt) set_dbg(1'b0, 1'b0, 32'h0);
    end
    set_core(1'b0, 1'b0, 32'h0);
    tick(); tick();

    // Alternating core and debug reads.
    for (int i = 0; i < 8; i++) begin
      set_core(i % 2 == 0, 1'b0, 32'h2000 + 32'(i));
      set_dbg(i % 2 == 1, 1'b0, 32'h3000 + 32'(i));
      tick();
    end
    set_core(1'b0, 1'b0, 32'h0);
    set_dbg(1'b0, 1'b0, 32'h0);
    tick();

    // Reset coinciding with a core read, then reset landing on a pending response.
    set_core(1'b1, 1'b0, 32'h500);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    set_core(1'b0, 1'b0, 32'h0);
    tick();
    set_core(1'b1, 1'b0, 32'h504);
    tick();
    set_core(1'b0, 1'b0, 32'h0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick(); tick();

    for (int i = 0; i < 3000; i++) begin
      drive_random(i < 1500 ? 85 : 50);
      tick();
    end
    rst_i = 1'b0;
    set_core(1'b0, 1'b0, 32'h0);
    set_dbg(1'b0, 1'b0, 32'h0);
    tick(); tick(); tick();
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
